ls_request_arbiter: RTL

Sits directly downstream of the load/store queue. Each cycle it chooses between the queue's ready load and ready store, with loads taking priority. The chosen request goes into a single registered issue stage that drives the memory subunits. Outstanding loads are tracked in an in-order attribute FIFO, so returning subunit data can be byte-aligned, sign-/zero-extended and written back with its instruction ID.

---
 rtl/ls_request_arbiter_pkg.sv | 25 ++
 rtl/ls_request_arbiter_if.sv | 62 ++++++
 rtl/ls_request_arbiter_fifo.sv | 50 +++++
 rtl/ls_request_arbiter.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/ls_request_arbiter_pkg.sv
// Shared types for the load/store request arbiter: RISC-V load funct3 codes,
// the issue-stage request word and an index-width helper.
package ls_request_arbiter_pkg;

  typedef logic [2:0] fn3_t;

  localparam fn3_t LS_B_fn3  = 3'b000;
  localparam fn3_t LS_H_fn3  = 3'b001;
  localparam fn3_t LS_W_fn3  = 3'b010;
  localparam fn3_t LS_BU_fn3 = 3'b100;
  localparam fn3_t LS_HU_fn3 = 3'b101;

  typedef struct packed {
    logic        rnw;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] data;
  } ls_req_t;

  // Index width that stays legal (>= 1 bit) even for a single-entry space.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ls_request_arbiter_if.sv
// Bundle of the queue-side, subunit-side and writeback signals of the arbiter.
// slave = arbiter view, master = load/store queue + memory subunit view.
interface ls_request_arbiter_if
  import ls_request_arbiter_pkg::*;
#(
  parameter int NUM_SUBUNITS = 4,
  parameter int ID_W         = 3
);
  localparam int SW = idx_w(NUM_SUBUNITS);

  logic                    load_valid;
  logic [31:0]             load_addr;
  fn3_t                    load_fn3;
  logic [ID_W-1:0]         load_id;
  logic [SW-1:0]           load_subunit;
  logic                    load_pop;

  logic                    store_valid;
  logic [31:0]             store_addr;
  logic [3:0]              store_be;
  logic [31:0]             store_data;
  logic [SW-1:0]           store_subunit;
  logic                    store_pop;

  logic                    req_valid;
  logic                    req_rnw;
  logic [31:0]             req_addr;
  logic [3:0]              req_be;
  logic [31:0]             req_data;
  logic [SW-1:0]           req_subunit;
  logic [NUM_SUBUNITS-1:0] req_ready;

  logic                    rsp_valid;
  logic [31:0]             rsp_data;

  logic                    wb_valid;
  logic [ID_W-1:0]         wb_id;
  logic [31:0]             wb_data;

  modport slave (
    input  load_valid, load_addr, load_fn3, load_id, load_subunit,
    output load_pop,
    input  store_valid, store_addr, store_be, store_data, store_subunit,
    output store_pop,
    output req_valid, req_rnw, req_addr, req_be, req_data, req_subunit,
    input  req_ready,
    input  rsp_valid, rsp_data,
    output wb_valid, wb_id, wb_data
  );

  modport master (
    output load_valid, load_addr, load_fn3, load_id, load_subunit,
    input  load_pop,
    output store_valid, store_addr, store_be, store_data, store_subunit,
    input  store_pop,
    input  req_valid, req_rnw, req_addr, req_be, req_data, req_subunit,
    output req_ready,
    output rsp_valid, rsp_data,
    input  wb_valid, wb_id, wb_data
  );

endinterface

// File: rtl/ls_request_arbiter_fifo.sv
// In-order circular FIFO, registered pointers, combinational head; 1-cycle push-to-head.
// No internal full/empty protection: the owner guarantees legal push/pop.
module ls_request_arbiter_fifo
  import ls_request_arbiter_pkg::*;
#(
  parameter type DATA_TYPE  = logic,
  parameter int  FIFO_DEPTH = 4
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     push,
  input  logic     pop,
  input  DATA_TYPE data_in,
  output DATA_TYPE data_out
);
  localparam int PTR_W = idx_w(FIFO_DEPTH);

  DATA_TYPE         mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = next_ptr(wr_ptr_q);
    if (pop)  rd_ptr_d = next_ptr(rd_ptr_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset; stale entries are unreachable once the pointers clear.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= data_in;
  end

  assign data_out = mem_q[rd_ptr_q];

endmodule

// File: rtl/ls_request_arbiter.sv
// Load-priority arbiter into one registered issue stage (1 cycle), pops combinational;
// the stage holds under req_ready backpressure, loads also stall while ATTR_DEPTH are outstanding.
module ls_request_arbiter
  import ls_request_arbiter_pkg::*;
#(
  parameter int NUM_SUBUNITS = 4,
  parameter int ATTR_DEPTH   = 4,
  parameter int ID_W         = 3
) (
  input logic                 clk,
  input logic                 rst,
  ls_request_arbiter_if.slave ls
);
  localparam int SW    = idx_w(NUM_SUBUNITS);
  localparam int CNT_W = $clog2(ATTR_DEPTH + 1);

  typedef struct packed {
    logic [ID_W-1:0] id;
    fn3_t            fn3;
    logic [1:0]      byte_off;
  } ls_rsp_attr_t;

  ls_req_t          req_q, req_d;
  logic             req_valid_q, req_valid_d;
  logic [SW-1:0]    req_subunit_q, req_subunit_d;

  logic [CNT_W-1:0] attr_cnt_q, attr_cnt_d;
  ls_rsp_attr_t     attr_in, attr_head;

  logic             wb_valid_q, wb_valid_d;
  logic [ID_W-1:0]  wb_id_q, wb_id_d;
  logic [31:0]      wb_data_q, wb_data_d;

  logic take, stage_free, attr_full, load_sel, store_sel, rsp_pop;

  function automatic logic [31:0] align_load(input logic [31:0] raw, input fn3_t fn3,
                                             input logic [1:0] off);
    logic [31:0] sh;
    sh = raw >> {off, 3'b000};
    case (fn3)
      LS_B_fn3:  align_load = {{24{sh[7]}}, sh[7:0]};
      LS_H_fn3:  align_load = {{16{sh[15]}}, sh[15:0]};
      LS_BU_fn3: align_load = {24'h0, sh[7:0]};
      LS_HU_fn3: align_load = {16'h0, sh[15:0]};
      default:   align_load = sh;
    endcase
  endfunction

  assign take       = req_valid_q & ls.req_ready[req_subunit_q];
  assign stage_free = ~req_valid_q | take;
  // Full is judged on the registered count, so a same-cycle response never admits a load.
  assign attr_full  = (attr_cnt_q == CNT_W'(ATTR_DEPTH));
  assign load_sel   = stage_free & ls.load_valid & ~attr_full;
  assign store_sel  = stage_free & ls.store_valid & ~load_sel;
  assign rsp_pop    = ls.rsp_valid & (attr_cnt_q != '0);

  assign ls.load_pop  = load_sel;
  assign ls.store_pop = store_sel;

  always_comb begin
    req_valid_d   = req_valid_q;
    req_d         = req_q;
    req_subunit_d = req_subunit_q;
    if (load_sel) begin
      req_valid_d   = 1'b1;
      req_d.rnw     = 1'b1;
      req_d.addr    = ls.load_addr;
      req_d.be      = 4'hF;
      req_d.data    = '0;
      req_subunit_d = ls.load_subunit;
    end else if (store_sel) begin
      req_valid_d   = 1'b1;
      req_d.rnw     = 1'b0;
      req_d.addr    = ls.store_addr;
      req_d.be      = ls.store_be;
      req_d.data    = ls.store_data;
      req_subunit_d = ls.store_subunit;
    end else if (take) begin
      req_valid_d   = 1'b0;
    end
  end

  always_comb begin
    attr_in.id       = ls.load_id;
    attr_in.fn3      = ls.load_fn3;
    attr_in.byte_off = ls.load_addr[1:0];
  end

  always_comb begin
    attr_cnt_d = attr_cnt_q;
    if (load_sel & ~rsp_pop)      attr_cnt_d = attr_cnt_q + CNT_W'(1);
    else if (rsp_pop & ~load_sel) attr_cnt_d = attr_cnt_q - CNT_W'(1);
  end

  ls_request_arbiter_fifo #(
    .DATA_TYPE  (ls_rsp_attr_t),
    .FIFO_DEPTH (ATTR_DEPTH)
  ) attr_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (load_sel),
    .pop      (rsp_pop),
    .data_in  (attr_in),
    .data_out (attr_head)
  );

  always_comb begin
    wb_valid_d = rsp_pop;
    wb_id_d    = wb_id_q;
    wb_data_d  = wb_data_q;
    if (rsp_pop) begin
      wb_id_d   = attr_head.id;
      wb_data_d = align_load(ls.rsp_data, attr_head.fn3, attr_head.byte_off);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_valid_q   <= 1'b0;
      req_q         <= '0;
      req_subunit_q <= '0;
      attr_cnt_q    <= '0;
      wb_valid_q    <= 1'b0;
      wb_id_q       <= '0;
      wb_data_q     <= '0;
    end else begin
      req_valid_q   <= req_valid_d;
      req_q         <= req_d;
      req_subunit_q <= req_subunit_d;
      attr_cnt_q    <= attr_cnt_d;
      wb_valid_q    <= wb_valid_d;
      wb_id_q       <= wb_id_d;
      wb_data_q     <= wb_data_d;
    end
  end

  assign ls.req_valid   = req_valid_q;
  assign ls.req_rnw     = req_q.rnw;
  assign ls.req_addr    = req_q.addr;
  assign ls.req_be      = req_q.be;
  assign ls.req_data    = req_q.data;
  assign ls.req_subunit = req_subunit_q;
  assign ls.wb_valid    = wb_valid_q;
  assign ls.wb_id       = wb_id_q;
  assign ls.wb_data     = wb_data_q;

  rsp_without_load: assert property (@(posedge clk) disable iff (rst)
    ls.rsp_valid |-> (attr_cnt_q != '0));

endmodule
